bus_scheduler: RTL and testbench
================================

Name: bus_scheduler

Overview:
- Shares the single 17-bit system bus (RAM, ROM shadow, VRAM, I/O) between three requesters: video fetch, SPI/MCU bridge and the 6502 CPU.
- Drives the bus address into the existing combinational address decoder and consumes its enables.
- Sequences each granted access through setup, strobe and acknowledge phases.
- Suppresses writes to read-only regions.

Parameters:
- RAM_CYCLES, 2, clocks that the RAM/IO strobe is held in ACCESS (legal range 1..15).
- ADDR_WIDTH, 17, bus address width.
- DATA_WIDTH, 8, bus data width.

Ports:
- clk_i  in  1  system clock; the only clock.
- reset_n_i  in  1  synchronous, active-low reset.
- video_req_i  in  1  video read request; held until video_ack_o.
- video_addr_i  in  ADDR_WIDTH  video read address.
- video_ack_o  out  1  one-clock pulse; rdata_o valid this cycle.
- spi_req_i  in  1  SPI request.
- spi_we_i  in  1  SPI write (1) / read (0).
- spi_addr_i  in  ADDR_WIDTH  SPI address.
- spi_wdata_i  in  DATA_WIDTH  SPI write data.
- spi_ack_o  out  1  one-clock completion pulse.
- cpu_req_i  in  1  CPU request.
- cpu_we_i  in  1  CPU write / read.
- cpu_addr_i  in  ADDR_WIDTH  CPU address.
- cpu_wdata_i  in  DATA_WIDTH  CPU write data.
- cpu_ack_o  out  1  one-clock completion pulse.
- rdata_o  out  DATA_WIDTH  read data captured from bus_rdata_i; held until the next ACK.
- bus_addr_o  out  ADDR_WIDTH  latched address; drives the decoder.
- bus_wdata_o  out  DATA_WIDTH  latched write data.
- bus_rdata_i  in  DATA_WIDTH  data returned from RAM/IO.
- ram_en_i, io_en_i, is_readonly_i  in  1 each  decoder outputs for bus_addr_o.
- ram_oe_o  out  1  RAM output enable.
- ram_we_o  out  1  RAM write enable.
- io_strobe_o  out  1  one-clock I/O cycle strobe.
- io_we_o  out  1  I/O direction, valid with io_strobe_o.

Behaviour:
- Reset:
  - While reset_n_i=0 at a rising edge, the next state is IDLE.
  - All outputs are 0, rdata_o=0, round-robin pointer = SPI.
  - Reset mid-access aborts the access with no ack and no strobe; the requester must re-request.
- States: IDLE, SETUP, ACCESS, ACK.
- IDLE:
  - If any req is high, arbitrate.
  - Latch the winner's id, addr, we and wdata (video we=0) into bus_addr_o/bus_wdata_o.
  - Go to SETUP.
- SETUP:
  - Lasts 1 clock; lets the decoder settle.
  - No strobes asserted.
  - Load the cycle counter with RAM_CYCLES-1.
- ACCESS:
  - Lasts RAM_CYCLES clocks.
  - ram_oe_o = ram_en_i & !we.
  - ram_we_o = ram_en_i & we & !is_readonly_i.
  - io_strobe_o = io_en_i, first ACCESS clock only.
  - io_we_o = we while io_strobe_o is high.
  - Neither enable asserted: the access completes silently and returns rdata = bus_rdata_i (don't-care).
- ACK:
  - Lasts 1 clock; rdata_o <= bus_rdata_i at entry.
  - The winner's ack_o is high for exactly this clock.
  - All strobes low; next state IDLE.
- Latency: request seen in IDLE at edge N gives ack high in cycle N+RAM_CYCLES+2 (edge count from sample). Throughput is one access per RAM_CYCLES+3 clocks.
- Arbitration:
  - Video has strict priority.
  - SPI and CPU share round-robin.
  - After serving SPI the pointer moves to CPU and vice versa; a video grant leaves the pointer unchanged.
  - A sole requester always wins regardless of the pointer.
- Request handshake:
  - Inputs are sampled only at grant; changes after grant are ignored.
  - If req drops before ack, the access still completes and ack still pulses.
  - req held high after ack counts as a new request in the following IDLE.
- Write to read-only (ROM shadow): ram_we_o stays 0; ack is still issued (a silent drop, not an error).
- At most one ack_o is high in any cycle; ack_o never fires outside ACK.

Decomposition:
- Package bus_scheduler_pkg:
  - state_t enum {IDLE, SETUP, ACCESS, ACK}.
  - req_id_t enum {REQ_VIDEO, REQ_SPI, REQ_CPU}.
  - Counter width constant = 4.
- One sub-module: bus_scheduler_arbiter (combinational priority + registered round-robin pointer; inputs req vector and pointer-update enable; output one-hot grant).

Test Plan:
- Reset release, then cpu read of 16'h0400 with bus_rdata_i=8'h5A and RAM_CYCLES=2: ram_oe_o high for 2 clocks, cpu_ack_o high 4 clocks after sample, rdata_o=8'h5A.
- cpu write 8'hAA to 17'h0F000 (is_readonly_i=1, ram_en_i=1): ram_we_o never asserted, cpu_ack_o pulses once.
- spi and cpu requesting continuously for 4 accesses: grants alternate SPI, CPU, SPI, CPU; then video asserts and wins the next grant, after which the pointer is unchanged.
- cpu read of 17'h0E812 (io_en_i=1, ram_en_i=0): io_strobe_o high exactly 1 clock with io_we_o=0, ram_oe_o=0, ack returns bus_rdata_i.
- reset_n_i pulsed low during the ACCESS of an spi write to 17'h08000: ram_we_o drops at the next edge, no spi_ack_o, state returns to IDLE, and the re-request completes normally.
- All three reqs high simultaneously for 12 accesses: never two ack_o in the same cycle, video served first each time it requests, and each ack is separated by RAM_CYCLES+3 clocks.

Source files
------------

// File: rtl/bus_scheduler_pkg.sv
// Shared types and constants for the system bus scheduler.
// Contents:
//   state_t    - access sequencer states (IDLE, SETUP, ACCESS, ACK)
//   req_id_t   - requester identity latched at grant time
//   CNT_WIDTH  - width of the ACCESS-phase cycle counter
//   NUM_REQ    - number of requesters
//   IDX_*      - bit positions of each requester in the request/grant vectors
package bus_scheduler_pkg;

  localparam int CNT_WIDTH = 4;
  localparam int NUM_REQ   = 3;

  // Request/grant vectors put video in bit 0, SPI in bit 1 and CPU in bit 2,
  // so these indices line up with the req_id_t encoding below.
  localparam int IDX_VIDEO = 0;
  localparam int IDX_SPI   = 1;
  localparam int IDX_CPU   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    ACK    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    REQ_VIDEO = 2'd0,
    REQ_SPI   = 2'd1,
    REQ_CPU   = 2'd2
  } req_id_t;

  // Turns a one-hot grant into the requester id that is stored for the
  // remainder of the access. An all-zero grant maps to video; callers only
  // use the result when some grant bit is set.
  function automatic req_id_t grantToId(input logic [NUM_REQ-1:0] grant);
    req_id_t id;
    id = REQ_VIDEO;
    if (grant[IDX_SPI]) begin
      id = REQ_SPI;
    end else if (grant[IDX_CPU]) begin
      id = REQ_CPU;
    end
    return id;
  endfunction

endpackage

// File: rtl/bus_scheduler_arbiter.sv
// Requester arbiter for the bus scheduler.
// Video has strict priority. SPI and CPU share the bus round-robin, with the
// turn pointer stored here. The pointer only moves when update_i is high,
// which happens on the cycle the scheduler actually accepts the grant.
// Ports:
//   clk_i, reset_n_i - system clock, synchronous active-low reset
//   req_i            - request vector {cpu, spi, video}
//   update_i         - grant accepted this cycle; advance the pointer
//   grant_o          - one-hot grant (all zero when nothing requests)
module bus_scheduler_arbiter
  import bus_scheduler_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               update_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic cpuTurn_q;
  logic cpuTurn_d;

  // Priority select. A lone SPI or CPU request wins whatever the pointer
  // says; the pointer only breaks a tie between the two.
  always_comb begin
    grant_o = '0;
    if (req_i[IDX_VIDEO]) begin
      grant_o[IDX_VIDEO] = 1'b1;
    end else if (req_i[IDX_SPI] && req_i[IDX_CPU]) begin
      if (cpuTurn_q) begin
        grant_o[IDX_CPU] = 1'b1;
      end else begin
        grant_o[IDX_SPI] = 1'b1;
      end
    end else if (req_i[IDX_SPI]) begin
      grant_o[IDX_SPI] = 1'b1;
    end else if (req_i[IDX_CPU]) begin
      grant_o[IDX_CPU] = 1'b1;
    end
  end

  // Pointer update. Serving SPI hands the next tie to CPU and vice versa.
  // A video grant leaves the pointer where it was.
  always_comb begin
    cpuTurn_d = cpuTurn_q;
    if (update_i) begin
      if (grant_o[IDX_SPI]) begin
        cpuTurn_d = 1'b1;
      end else if (grant_o[IDX_CPU]) begin
        cpuTurn_d = 1'b0;
      end
    end
  end

  // Pointer register. Reset gives SPI the first tie.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cpuTurn_q <= 1'b0;
    end else begin
      cpuTurn_q <= cpuTurn_d;
    end
  end

endmodule

// File: rtl/bus_scheduler.sv
// System bus scheduler.
// Shares the single system bus between three requesters: video fetch, the
// SPI/MCU bridge and the CPU. Each granted access runs through four phases:
//   IDLE   - arbitrate, then latch address, write data and direction
//   SETUP  - one quiet clock so the external decoder can settle
//   ACCESS - RAM_CYCLES clocks of RAM strobes; the I/O strobe lasts one clock
//   ACK    - one clock with the winner's ack and captured read data
// Writes to regions the decoder marks read-only are dropped silently, but the
// requester still receives its ack.
// Ports:
//   clk_i, reset_n_i               - system clock, synchronous active-low reset
//   video_req_i/addr_i, video_ack_o - video read port
//   spi_req/we/addr/wdata_i, spi_ack_o - SPI bridge port
//   cpu_req/we/addr/wdata_i, cpu_ack_o - CPU port
//   rdata_o                        - read data, held until the next ack
//   bus_addr_o, bus_wdata_o        - latched bus address and write data
//   bus_rdata_i                    - data returned by RAM/IO
//   ram_en_i, io_en_i, is_readonly_i - decoder results for bus_addr_o
//   ram_oe_o, ram_we_o             - RAM output and write enables
//   io_strobe_o, io_we_o           - single-clock I/O cycle and its direction
module bus_scheduler
  import bus_scheduler_pkg::*;
#(
  parameter int RAM_CYCLES = 2,  // legal range 1..15
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  video_req_i,
  input  logic [ADDR_WIDTH-1:0] video_addr_i,
  output logic                  video_ack_o,
  input  logic                  spi_req_i,
  input  logic                  spi_we_i,
  input  logic [ADDR_WIDTH-1:0] spi_addr_i,
  input  logic [DATA_WIDTH-1:0] spi_wdata_i,
  output logic                  spi_ack_o,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic                  cpu_ack_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i,
  input  logic                  ram_en_i,
  input  logic                  io_en_i,
  input  logic                  is_readonly_i,
  output logic                  ram_oe_o,
  output logic                  ram_we_o,
  output logic                  io_strobe_o,
  output logic                  io_we_o
);

  // The counter counts down from this value, so the first ACCESS clock is
  // the one where the counter still holds it.
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(RAM_CYCLES - 1);

  state_t                state_q, state_d;
  req_id_t               id_q, id_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [NUM_REQ-1:0]    reqVec;
  logic [NUM_REQ-1:0]    grant;
  logic                  grantEn;

  assign reqVec  = {cpu_req_i, spi_req_i, video_req_i};
  assign grantEn = (state_q == IDLE) && (|reqVec);

  bus_scheduler_arbiter u_arbiter (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .req_i    (reqVec),
    .update_i (grantEn),
    .grant_o  (grant)
  );

  // Sequencer next-state logic. Requester inputs are only looked at on the
  // grant cycle; after that the access runs entirely from the latched copy.
  // Read data is captured on the last ACCESS clock so it is already valid
  // in rdata_o during ACK.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grantEn) begin
          state_d = SETUP;
          id_d    = grantToId(grant);
          if (grant[IDX_VIDEO]) begin
            we_d    = 1'b0;
            addr_d  = video_addr_i;
            wdata_d = '0;
          end else if (grant[IDX_SPI]) begin
            we_d    = spi_we_i;
            addr_d  = spi_addr_i;
            wdata_d = spi_wdata_i;
          end else begin
            we_d    = cpu_we_i;
            addr_d  = cpu_addr_i;
            wdata_d = cpu_wdata_i;
          end
        end
      end
      SETUP: begin
        cnt_d   = CNT_LOAD;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ACK;
          rdata_d = bus_rdata_i;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers. Reset lands in IDLE from any state, which aborts an
  // in-flight access without an ack.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      id_q    <= REQ_VIDEO;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bus strobes and acks. These are decoded from the registered state plus
  // the decoder enables. The decoder enables are stable because bus_addr_o
  // has been held since SETUP. A read-only region masks only the write
  // enable; the access still runs its full length and acks.
  always_comb begin
    ram_oe_o    = 1'b0;
    ram_we_o    = 1'b0;
    io_strobe_o = 1'b0;
    io_we_o     = 1'b0;
    video_ack_o = 1'b0;
    spi_ack_o   = 1'b0;
    cpu_ack_o   = 1'b0;
    if (state_q == ACCESS) begin
      ram_oe_o = ram_en_i & ~we_q;
      ram_we_o = ram_en_i & we_q & ~is_readonly_i;
      if (cnt_q == CNT_LOAD) begin
        io_strobe_o = io_en_i;
        io_we_o     = io_en_i & we_q;
      end
    end
    if (state_q == ACK) begin
      video_ack_o = (id_q == REQ_VIDEO);
      spi_ack_o   = (id_q == REQ_SPI);
      cpu_ack_o   = (id_q == REQ_CPU);
    end
  end

  assign rdata_o     = rdata_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_bus_scheduler.sv
// Directed self-checking bench for bus_scheduler (RAM_CYCLES = 2).
// A small address decoder is modelled here:
//   I/O window at 17'h0E8xx, ROM shadow (read-only RAM) at 17'h0Fxxx,
//   everything else RAM.
// Read data returned by the bus is addr[7:0] ^ 8'h5A.
module tb_bus_scheduler;

  logic        clk = 1'b0;
  logic        resetN;
  logic        videoReq, spiReq, spiWe, cpuReq, cpuWe;
  logic [16:0] videoAddr, spiAddr, cpuAddr;
  logic [7:0]  spiWdata, cpuWdata;
  logic        videoAck, spiAck, cpuAck;
  logic [7:0]  rdata, busWdata, busRdata;
  logic [16:0] busAddr;
  logic        ramEn, ioEn, readOnly;
  logic        ramOe, ramWe, ioStrobe, ioWe;

  int errCount   = 0;
  int checkCount = 0;

  // Counters maintained by the monitor and sampled on falling edges.
  int ackCnt [3] = '{0, 0, 0};
  int ramOeCycles = 0, ramWeCycles = 0, ioStrobeCycles = 0, ioWeCycles = 0;
  int multiAck = 0;
  int cycleNum = 0;
  int ackIds [$];
  int ackCyc [$];

  // Sequence tables consumed by runSequence.
  logic       vidPat [12];
  logic [1:0] expSeq [12];

  always #5 clk = ~clk;

  assign ioEn     = (busAddr[16:8] == 9'h0E8);
  assign ramEn    = ~ioEn;
  assign readOnly = (busAddr[16:12] == 5'h0F);
  assign busRdata = busAddr[7:0] ^ 8'h5A;

  bus_scheduler dut (
    .clk_i        (clk),
    .reset_n_i    (resetN),
    .video_req_i  (videoReq),
    .video_addr_i (videoAddr),
    .video_ack_o  (videoAck),
    .spi_req_i    (spiReq),
    .spi_we_i     (spiWe),
    .spi_addr_i   (spiAddr),
    .spi_wdata_i  (spiWdata),
    .spi_ack_o    (spiAck),
    .cpu_req_i    (cpuReq),
    .cpu_we_i     (cpuWe),
    .cpu_addr_i   (cpuAddr),
    .cpu_wdata_i  (cpuWdata),
    .cpu_ack_o    (cpuAck),
    .rdata_o      (rdata),
    .bus_addr_o   (busAddr),
    .bus_wdata_o  (busWdata),
    .bus_rdata_i  (busRdata),
    .ram_en_i     (ramEn),
    .io_en_i      (ioEn),
    .is_readonly_i(readOnly),
    .ram_oe_o     (ramOe),
    .ram_we_o     (ramWe),
    .io_strobe_o  (ioStrobe),
    .io_we_o      (ioWe)
  );

  always @(posedge clk) cycleNum <= cycleNum + 1;

  // Monitor: strobe and ack bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    if (ramOe)    ramOeCycles++;
    if (ramWe)    ramWeCycles++;
    if (ioStrobe) ioStrobeCycles++;
    if (ioWe)     ioWeCycles++;
    if ((int'(videoAck) + int'(spiAck) + int'(cpuAck)) > 1) multiAck++;
    if (videoAck) begin ackCnt[0]++; ackIds.push_back(0); ackCyc.push_back(cycleNum); end
    if (spiAck)   begin ackCnt[1]++; ackIds.push_back(1); ackCyc.push_back(cycleNum); end
    if (cpuAck)   begin ackCnt[2]++; ackIds.push_back(2); ackCyc.push_back(cycleNum); end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycle();
    @(negedge clk);
    #1;
  endtask

  // Issue one request and hold it until its ack; latency counts clocks from
  // the sampling IDLE cycle to the ACK cycle.
  task automatic applyStimulus(input int which, input logic we, input logic [16:0] addr,
                               input logic [7:0] wdata, output int latency);
    int base;
    base    = ackCnt[which];
    latency = 0;
    case (which)
      0:       begin videoReq = 1'b1; videoAddr = addr; end
      1:       begin spiReq = 1'b1; spiWe = we; spiAddr = addr; spiWdata = wdata; end
      default: begin cpuReq = 1'b1; cpuWe = we; cpuAddr = addr; cpuWdata = wdata; end
    endcase
    while (ackCnt[which] == base && latency < 40) begin
      waitCycle();
      latency++;
    end
    if (ackCnt[which] == base) checkOutput("ack_timeout", 32'd0, 32'd1);
    videoReq = 1'b0;
    spiReq   = 1'b0;
    cpuReq   = 1'b0;
  endtask

  // SPI and CPU request continuously; video follows vidPat per access.
  // The grant order and the ack spacing are checked against expSeq.
  task automatic runSequence(input int n, input string tag);
    int base, guard;
    base     = ackIds.size();
    spiWe    = 1'b0; spiAddr = 17'h00100;
    cpuWe    = 1'b0; cpuAddr = 17'h00200;
    videoAddr = 17'h00300;
    spiReq   = 1'b1;
    cpuReq   = 1'b1;
    videoReq = vidPat[0];
    for (int k = 0; k < n; k++) begin
      guard = 0;
      while (ackIds.size() <= base + k && guard < 30) begin
        waitCycle();
        guard++;
      end
      if (ackIds.size() <= base + k) begin
        checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
        break;
      end
      if (k + 1 < n) videoReq = vidPat[k + 1];
    end
    videoReq = 1'b0;
    spiReq   = 1'b0;
    cpuReq   = 1'b0;
    for (int k = 0; k < n && base + k < ackIds.size(); k++) begin
      checkOutput($sformatf("%s_grant%0d", tag, k), ackIds[base + k], 32'(expSeq[k]));
      if (k > 0)
        checkOutput($sformatf("%s_gap%0d", tag, k),
                    ackCyc[base + k] - ackCyc[base + k - 1], 32'd5);
    end
  endtask

  task automatic doReset();
    resetN = 1'b0;
    waitCycle();
    waitCycle();
    resetN = 1'b1;
  endtask

  initial begin
    int lat, oeB, weB, ioB, iowB, ackB, multiB, guard;
    resetN = 1'b0;
    videoReq = 1'b0; spiReq = 1'b0; cpuReq = 1'b0;
    spiWe = 1'b0; cpuWe = 1'b0;
    videoAddr = '0; spiAddr = '0; cpuAddr = '0;
    spiWdata = '0; cpuWdata = '0;

    // Reset state.
    waitCycle();
    waitCycle();
    checkOutput("rst_rdata", 32'(rdata), 32'h0);
    checkOutput("rst_addr", 32'(busAddr), 32'h0);
    checkOutput("rst_strobes", {28'd0, ramOe, ramWe, ioStrobe, ioWe}, 32'h0);
    checkOutput("rst_acks", {29'd0, videoAck, spiAck, cpuAck}, 32'h0);
    resetN = 1'b1;
    waitCycle();

    // CPU RAM read.
    oeB = ramOeCycles;
    applyStimulus(2, 1'b0, 17'h00400, 8'h00, lat);
    checkOutput("rd_latency", lat, 32'd4);
    checkOutput("rd_rdata", 32'(rdata), 32'h5A);
    checkOutput("rd_oe_cycles", ramOeCycles - oeB, 32'd2);
    waitCycle();
    checkOutput("rd_rdata_hold", 32'(rdata), 32'h5A);

    // CPU write to the ROM shadow: dropped, still acked exactly once.
    weB = ramWeCycles; ackB = ackCnt[2];
    applyStimulus(2, 1'b1, 17'h0F000, 8'hAA, lat);
    waitCycle(); waitCycle(); waitCycle();
    checkOutput("ro_latency", lat, 32'd4);
    checkOutput("ro_we_cycles", ramWeCycles - weB, 32'd0);
    checkOutput("ro_ack_count", ackCnt[2] - ackB, 32'd1);
    checkOutput("ro_wdata", 32'(busWdata), 32'hAA);

    // SPI write to ordinary RAM.
    weB = ramWeCycles;
    applyStimulus(1, 1'b1, 17'h08000, 8'h3C, lat);
    checkOutput("wr_we_cycles", ramWeCycles - weB, 32'd2);
    checkOutput("wr_wdata", 32'(busWdata), 32'h3C);

    // CPU I/O read.
    oeB = ramOeCycles; ioB = ioStrobeCycles; iowB = ioWeCycles;
    applyStimulus(2, 1'b0, 17'h0E812, 8'h00, lat);
    checkOutput("io_rd_strobe", ioStrobeCycles - ioB, 32'd1);
    checkOutput("io_rd_we", ioWeCycles - iowB, 32'd0);
    checkOutput("io_rd_oe", ramOeCycles - oeB, 32'd0);
    checkOutput("io_rd_rdata", 32'(rdata), 32'h48);

    // CPU I/O write.
    weB = ramWeCycles; ioB = ioStrobeCycles; iowB = ioWeCycles;
    applyStimulus(2, 1'b1, 17'h0E800, 8'h77, lat);
    checkOutput("io_wr_strobe", ioStrobeCycles - ioB, 32'd1);
    checkOutput("io_wr_we", ioWeCycles - iowB, 32'd1);
    checkOutput("io_wr_ram_we", ramWeCycles - weB, 32'd0);

    // Round robin then video; the pointer returns to SPI afterwards.
    doReset();
    vidPat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    expSeq = '{1, 2, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0};
    runSequence(6, "rr");
    waitCycle(); waitCycle();

    // Reset during the ACCESS of an SPI write, then re-request.
    ackB = ackCnt[1];
    spiWe = 1'b1; spiAddr = 17'h08000; spiWdata = 8'h3C; spiReq = 1'b1;
    guard = 0;
    while (!ramWe && guard < 20) begin waitCycle(); guard++; end
    checkOutput("abort_we_seen", 32'(ramWe), 32'd1);
    resetN = 1'b0;
    waitCycle();
    checkOutput("abort_we_drop", 32'(ramWe), 32'd0);
    checkOutput("abort_addr_idle", 32'(busAddr), 32'h0);
    checkOutput("abort_rdata", 32'(rdata), 32'h0);
    resetN = 1'b1;
    checkOutput("abort_no_ack", ackCnt[1] - ackB, 32'd0);
    weB = ramWeCycles;
    guard = 0;
    while (ackCnt[1] == ackB && guard < 20) begin waitCycle(); guard++; end
    spiReq = 1'b0;
    checkOutput("abort_retry_latency", guard, 32'd4);
    checkOutput("abort_retry_ack", ackCnt[1] - ackB, 32'd1);
    checkOutput("abort_retry_we", ramWeCycles - weB, 32'd2);
    waitCycle(); waitCycle();

    // All three requesting for 12 accesses, video on and off.
    doReset();
    multiB = multiAck;
    vidPat = '{1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0};
    expSeq = '{0, 1, 2, 0, 0, 1, 2, 1, 0, 2, 1, 2};
    runSequence(12, "all");
    waitCycle();
    checkOutput("all_single_ack", multiAck - multiB, 32'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

  // Global time bound against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
